stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 39 +++
 rtl/bcd_digit.sv | 49 ++++
 rtl/stopwatch_ctrl.sv | 177 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// ----------------------------------------------------------------------------
// stopwatch_pkg
//
// Purpose:
//     Shared definitions for the two-digit BCD stopwatch: the controller
//     state enumeration, the BCD digit width, the units-digit terminal value
//     and a small helper that computes the next value of a mod-N BCD digit.
//
// Contents:
//     state_t   - controller states IDLE, RUN, PAUSE
//     DIGIT_W   - width of one BCD digit (4)
//     BCD_MAX   - terminal value of a full decade digit (9)
//     bcd_next  - next digit value, rolling to 0 after the terminal value
// ----------------------------------------------------------------------------
package stopwatch_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Rolling on ">=" rather than "==" means a digit can never climb past its
    // terminal value, even if the terminal value were lowered at runtime.
    function automatic logic [DIGIT_W-1:0] bcd_next(
        input logic [DIGIT_W-1:0] value,
        input logic [DIGIT_W-1:0] maxValue
    );
        if (value >= maxValue) begin
            return '0;
        end
        return value + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// ----------------------------------------------------------------------------
// bcd_digit
//
// Purpose:
//     One mod-N BCD digit. It counts 0..max_val when enabled and raises a
//     combinational carry on the enabled cycle in which it rolls back to 0,
//     so a chain of these forms a multi-digit counter.
//
// Ports:
//     clk      in   clock, all state updates on posedge
//     rst      in   synchronous reset, active-low
//     clr      in   synchronous clear to 0 (lower priority than rst)
//     en       in   advance the digit by one this cycle
//     max_val  in   terminal value of the digit (9 for a full decade)
//     value    out  current digit value (registered)
//     carry    out  high when en is set and the digit is at its terminal value
// ----------------------------------------------------------------------------
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [DIGIT_W-1:0] max_val,
    output logic [DIGIT_W-1:0] value,
    output logic               carry
);

    logic [DIGIT_W-1:0] r_value;

    // Digit register: reset and clear both force zero, otherwise advance
    // only on enable so a held digit keeps its value indefinitely.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (en) begin
            r_value <= bcd_next(r_value, max_val);
        end
    end

    // The carry is combinational so the next digit advances on the same edge
    // that this digit rolls over.
    assign carry = en && (r_value >= max_val);
    assign value = r_value;

endmodule

// File: rtl/stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Purpose:
//     Two-digit BCD stopwatch controller. A three-state FSM (IDLE, RUN,
//     PAUSE) decides when tick strobes advance a units/tens BCD counter built
//     from two bcd_digit instances. Commands are prioritised clear, then
//     stop, then start. A one-cycle wrap pulse flags the roll from
//     TENS_MAX,9 back to 0,0.
//
// Parameters:
//     TENS_MAX   terminal value of the tens digit, legal range 1..9
//
// Ports:
//     clk        in   clock, all state updates on posedge
//     rst        in   synchronous reset, active-low
//     tick       in   count-enable strobe, one cycle wide
//     start      in   begin or resume counting
//     stop       in   pause counting
//     clear      in   return to IDLE and zero the digits
//     lap        in   (STOPWATCH_LAP_EN only) capture / release lap display
//     ones       out  BCD units digit shown on the display
//     tens       out  BCD tens digit shown on the display
//     running    out  high while in RUN (registered)
//     wrap       out  one-cycle pulse after the roll to 0,0 (registered)
//     lap_valid  out  (STOPWATCH_LAP_EN only) display shows the held lap value
//
// Configuration:
//     STOPWATCH_LAP_EN  when defined, adds the lap/lap_valid ports and a lap
//                       hold register that freezes the display while the live
//                       count keeps running. Undefined by default.
// ----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TENS_MAX = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
`ifdef STOPWATCH_LAP_EN
    input  logic               lap,
    output logic               lap_valid,
`endif
    output logic [DIGIT_W-1:0] ones,
    output logic [DIGIT_W-1:0] tens,
    output logic               running,
    output logic               wrap
);

    localparam logic [DIGIT_W-1:0] TENS_MAX_V = DIGIT_W'(TENS_MAX);

    state_t             r_state;
    logic               r_running;
    logic               r_wrap;

    logic               w_advance;
    logic               w_onesCarry;
    logic               w_tensCarry;
    logic [DIGIT_W-1:0] w_onesLive;
    logic [DIGIT_W-1:0] w_tensLive;

    // A tick only counts when already in RUN. A start arriving with the tick
    // has not yet moved the state, so that tick is deliberately dropped; clear
    // and stop win over the tick in the same cycle.
    assign w_advance = (r_state == RUN) && tick && !clear && !stop;

    bcd_digit u_ones (
        .clk     (clk),
        .rst     (rst),
        .clr     (clear),
        .en      (w_advance),
        .max_val (BCD_MAX),
        .value   (w_onesLive),
        .carry   (w_onesCarry)
    );

    bcd_digit u_tens (
        .clk     (clk),
        .rst     (rst),
        .clr     (clear),
        .en      (w_onesCarry),
        .max_val (TENS_MAX_V),
        .value   (w_tensLive),
        .carry   (w_tensCarry)
    );

    // Controller FSM with its registered outputs. running is set from the
    // state being entered so it always matches r_state. The tens carry only
    // fires when both digits are at their terminal values during an advance,
    // which is exactly the roll to 0,0, so registering it gives a pulse that
    // lines up with the zeroed digits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_wrap <= w_tensCarry;
            if (clear) begin
                r_state   <= IDLE;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start && !stop) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            r_state   <= PAUSE;
                            r_running <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (start && !stop) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign running = r_running;
    assign wrap    = r_wrap;

`ifdef STOPWATCH_LAP_EN

    logic               r_lapValid;
    logic [DIGIT_W-1:0] r_lapOnes;
    logic [DIGIT_W-1:0] r_lapTens;

    // Lap hold: the first lap in RUN snapshots the live digits (their value
    // before any advance in the same cycle), the next lap releases the
    // display. Clear also releases it; the snapshot itself is only zeroed by
    // reset because it is invisible whenever lap_valid is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lapValid <= 1'b0;
            r_lapOnes  <= '0;
            r_lapTens  <= '0;
        end else if (clear) begin
            r_lapValid <= 1'b0;
        end else if ((r_state == RUN) && lap) begin
            if (!r_lapValid) begin
                r_lapValid <= 1'b1;
                r_lapOnes  <= w_onesLive;
                r_lapTens  <= w_tensLive;
            end else begin
                r_lapValid <= 1'b0;
            end
        end
    end

    assign ones      = r_lapValid ? r_lapOnes : w_onesLive;
    assign tens      = r_lapValid ? r_lapTens : w_tensLive;
    assign lap_valid = r_lapValid;

`else

    assign ones = w_onesLive;
    assign tens = w_tensLive;

`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Purpose:
//     Self-checking bench for stopwatch_ctrl built with TENS_MAX=5. A
//     behavioural model holds the elapsed count as a single integer and the
//     controller mode, and a compare process checks every output against it
//     on each falling edge. Directed sequences with literal expectations pin
//     the model, followed by a randomized command/tick phase.
//     Honours STOPWATCH_LAP_EN for the lap port and lap checks.
// ----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int TM     = 5;
    localparam int SPAN   = (TM + 1) * 10;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       start;
    logic       stop;
    logic       clear;
    logic       lap;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       running;
    logic       wrap;
`ifdef STOPWATCH_LAP_EN
    logic       lap_valid;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Model state: elapsed count 0..SPAN-1, mode, wrap flag, lap snapshot.
    bit modelValid = 1'b0;
    int mMode      = M_IDLE;
    int mCnt       = 0;
    bit mWrap      = 1'b0;
    bit mLapValid  = 1'b0;
    int mLapCnt    = 0;

    stopwatch_ctrl #(.TENS_MAX(TM)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
`ifdef STOPWATCH_LAP_EN
        .lap       (lap),
        .lap_valid (lap_valid),
`endif
        .ones      (ones),
        .tens      (tens),
        .running   (running),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model, advanced on every rising edge from the driven inputs.
    always @(posedge clk) begin
        if (!rst) begin
            modelValid = 1'b1;
            mMode      = M_IDLE;
            mCnt       = 0;
            mWrap      = 1'b0;
            mLapValid  = 1'b0;
            mLapCnt    = 0;
        end else if (modelValid) begin
            mWrap = 1'b0;
            if (clear) begin
                mMode     = M_IDLE;
                mCnt      = 0;
                mLapValid = 1'b0;
            end else begin
`ifdef STOPWATCH_LAP_EN
                if (mMode == M_RUN && lap) begin
                    if (mLapValid) begin
                        mLapValid = 1'b0;
                    end else begin
                        mLapValid = 1'b1;
                        mLapCnt   = mCnt;
                    end
                end
`endif
                if (mMode == M_RUN && tick && !stop) begin
                    mWrap = (mCnt == SPAN - 1);
                    mCnt  = (mCnt + 1) % SPAN;
                end
                if (stop) begin
                    if (mMode == M_RUN) mMode = M_PAUSE;
                end else if (start && mMode != M_RUN) begin
                    mMode = M_RUN;
                end
            end
        end
    end

    task automatic checkOne(input string name, input int actual, input int expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: every falling edge once the model has seen reset.
    always @(negedge clk) begin
        if (modelValid) begin
            int shown;
            shown = mLapValid ? mLapCnt : mCnt;
            checkOne("model.ones",    int'(ones),    shown % 10);
            checkOne("model.tens",    int'(tens),    shown / 10);
            checkOne("model.running", int'(running), (mMode == M_RUN) ? 1 : 0);
            checkOne("model.wrap",    int'(wrap),    int'(mWrap));
`ifdef STOPWATCH_LAP_EN
            checkOne("model.lap_valid", int'(lap_valid), int'(mLapValid));
`endif
        end
    end

    // Drive one cycle of inputs, then return at the following falling edge.
    task automatic applyStimulus(input bit rstV, input bit startV, input bit stopV,
                                 input bit clearV, input bit tickV, input bit lapV);
        rst   = rstV;
        start = startV;
        stop  = stopV;
        clear = clearV;
        tick  = tickV;
        lap   = lapV;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 1, 0);
    endtask

    task automatic checkOutput(input string name, input int expTens, input int expOnes,
                               input int expRunning, input int expWrap);
        checkOne({name, ".ones"},    int'(ones),    expOnes);
        checkOne({name, ".tens"},    int'(tens),    expTens);
        checkOne({name, ".running"}, int'(running), expRunning);
        checkOne({name, ".wrap"},    int'(wrap),    expWrap);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; tick = 1'b0; lap = 1'b0;

        $display("[TB] reset with start and tick held");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 1, 0);
            checkOutput("reset", 0, 0, 0, 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset.release", 0, 0, 0, 0);

        $display("[TB] count, pause, resume");
        applyStimulus(1, 1, 0, 0, 0, 0);
        ticks(25);
        checkOutput("run25", 2, 5, 1, 0);
        applyStimulus(1, 0, 1, 0, 0, 0);
        ticks(5);
        checkOutput("paused", 2, 5, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        ticks(1);
        checkOutput("resume", 2, 6, 1, 0);

        $display("[TB] wrap at TENS_MAX");
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        ticks(SPAN - 1);
        checkOutput("last", TM, 9, 1, 0);
        ticks(1);
        checkOutput("wrap", 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("wrap.after", 0, 0, 1, 0);

        $display("[TB] same-cycle commands");
        applyStimulus(1, 0, 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 1, 0);
        checkOutput("start_tick", 0, 0, 1, 0);
        ticks(3);
        applyStimulus(1, 0, 1, 0, 1, 0);
        checkOutput("stop_tick", 0, 3, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        ticks(44);
        checkOutput("at47", 4, 7, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 0);
        checkOutput("clear_tick", 0, 0, 0, 0);

        $display("[TB] reset during run");
        applyStimulus(1, 1, 0, 0, 0, 0);
        ticks(38);
        checkOutput("at38", 3, 8, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("rst_run", 0, 0, 0, 0);
        ticks(5);
        checkOutput("rst_idle", 0, 0, 0, 0);

`ifdef STOPWATCH_LAP_EN
        $display("[TB] lap hold");
        applyStimulus(1, 1, 0, 0, 0, 0);
        ticks(12);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOne("lap1.valid", int'(lap_valid), 1);
        ticks(10);
        checkOutput("lap.hold", 1, 2, 1, 0);
        checkOne("lap.hold.valid", int'(lap_valid), 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("lap.release", 2, 2, 1, 0);
        checkOne("lap.release.valid", int'(lap_valid), 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
`endif

        $display("[TB] randomized phase");
        for (int i = 0; i < 4000; i++) begin
            applyStimulus($urandom_range(0, 99) != 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 59) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 24) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
